seg7_display_arbiter: RTL and testbench
=======================================

// Module: seg7_display_arbiter
// PURPOSE
//  Shares the 4-digit seven-segment display between NREQ requesters, each presenting 4 BCD digits.
//  Grants one owner at a time under round-robin with a minimum hold time; it then scans the owner's digits.
//  Scanning uses a single-clock tick enable, not a derived clock.
//  Sits between the button/counter logic and the board display pins.
// PARAMETERS
//  NREQ        4      number of requesters (2..8)
//  CYCLE       80000  clk cycles per digit slot (scan_tick period)
//  HOLD_FRAMES 250    minimum full frames (1 frame = 4 slots) an owner keeps the display
// PORTS
//  clk        in   1        system clock, rising edge
//  rst        in   1        asynchronous reset, active-high
//  req        in   NREQ     req[i]=1: requester i wants the display (level)
//  data       in   16*NREQ  data[16i+4d+:4] = digit d of requester i (0-9 digit, 10 dash, 11-15 blank)
//  gnt        out  NREQ     one-hot current owner; all-zero when idle
//  seg7       out  8        segment pattern, active-high, bit7 = dp (always 0)
//  seg7_sel   out  4        one-hot digit enable, bit d = digit d
//  frame_done out  1        1-cycle pulse at each frame boundary
// BEHAVIOUR
//  Reset (async, immediate): gnt=0, seg7=0, seg7_sel=0, frame_done=0, tick cnt=0, idx=0, state=IDLE,
//   hold_cnt=0, rr_ptr=NREQ-1 (requester 0 wins first).
//  Tick: cnt counts 0..CYCLE-1 and wraps. scan_tick is high the single cycle when cnt==CYCLE-1.
//  On each scan_tick: seg7_sel<=onehot(idx), seg7<=dec(digit idx), idx<=idx+1 (wraps 3->0).
//   The digit source for idx 0 is live data[owner] (also loaded into a 16b shadow); idx 1-3 use the shadow.
//   This makes frames tear-free.
//  Frame boundary = scan_tick with idx==3. frame_done=1 on the cycle after it.
//  All gnt changes happen only at frame boundaries, so a new owner always starts at digit 0.
//  Decoder: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F 10=40 (dash), 11-15=00 (blank).
//  No owner (IDLE): seg7_sel=0000 and seg7=00 on every tick; idx still runs.
//  FSM IDLE/OWN, evaluated at each frame boundary:
//   IDLE: any req -> OWN. gnt = first set req scanning rr_ptr+1, rr_ptr+2, ... (mod NREQ).
//    rr_ptr<=winner, hold_cnt<=0.
//   OWN, hold_cnt sat-increments (max HOLD_FRAMES); let h = value after increment:
//    owner req=0 and no other req -> IDLE, gnt=0 (a release ignores the hold).
//    owner req=0 and other req     -> grant next RR requester, hold_cnt<=0.
//    owner req=1, other req, h>=HOLD_FRAMES -> grant next RR requester (the owner is excluded), hold_cnt<=0.
//    otherwise stay; owner is never re-granted to itself.
//  Latency: req edge to gnt is at most 4*CYCLE+1 clk. gnt drop to display blank is at most 4*CYCLE+1 clk.
//  Simultaneous requests: resolved purely by RR order from rr_ptr. Mid-frame req changes are ignored until the boundary.
//  data changes mid-frame: visible only from the next frame (idx 0 load).
//  Reset mid-frame: outputs cleared the same instant. First tick after release is CYCLE cycles later.
// STRUCTURE
//  seg7_pkg: decoder pattern constants, FSM state encoding (IDLE=0, OWN=1).
//  Sub-module seg7_decoder: combinational 4b->8b pattern. Shared with other display blocks.
//  Top: tick divider, idx counter, RR arbiter FSM, shadow register, output regs.
// TESTING (bench: CYCLE=4, HOLD_FRAMES=2, NREQ=4; frame = 16 clk)
//  1 Reset then idle 3 frames -> gnt=0000, seg7_sel=0000, seg7=00. frame_done pulses every 16 clk.
//  2 req=0001, data0=16'h4321 -> at the next boundary gnt=0001.
//    Following ticks: sel 0001/3F? no -> sel 0001 seg 06, sel 0010 seg 5B, sel 0100 seg 4F, sel 1000 seg 66.
//  3 req=1111 from idle, all held -> gnt order 0001,0010,0100,1000,0001, each owned exactly 2 frames.
//  4 Owner 0 drops req after 1 frame, req2 set -> gnt=0100 at that boundary (hold ignored).
//    Drop with no others -> gnt=0000, display blank.
//  5 data0 changes 16'h0000->16'hAAAA while idx=2 -> current frame still shows 3F on sel 0100/1000.
//    Next frame shows 40 on all digits. Code 16'hFFFF -> seg7=00.
//  6 Assert rst mid-frame while owning -> gnt, seg7, seg7_sel, frame_done are 0 immediately.
//    After release with req=0010, requester 1 is granted first (rr_ptr reset).
```

Correction to line 2 of TESTING: the required sequence is sel 0001 seg 06, sel 0010 seg 5B, sel 0100 seg 4F, sel 1000 seg 66. Digit d takes data0[4d+:4], so 16'h4321 gives digit0=1, digit1=2, digit2=3, digit3=4.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display blocks: segment patterns
// (active-high, bit7 = dp) and arbiter FSM state encoding.
package seg7_pkg;

  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_DASH  = 8'h40;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_OWN  = 1'b1;

  function automatic logic [3:0] digit_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD-to-segment decoder: 0-9 digits, 10 dash, 11-15 blank.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [7:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_code)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      4'd10:   o_seg = SEG_DASH;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_display_arbiter.sv
// Round-robin owner arbitration with minimum hold for a shared 4-digit display,
// plus tick-enabled digit scanning with a per-frame shadow of the owner's digits.
module seg7_display_arbiter
  import seg7_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int CYCLE       = 80000,
  parameter int HOLD_FRAMES = 250
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   data,
  output logic [NREQ-1:0]      gnt,
  output logic [7:0]           seg7,
  output logic [3:0]           seg7_sel,
  output logic                 frame_done
);

  localparam int CW = (CYCLE > 1) ? $clog2(CYCLE) : 1;
  localparam int PW = $clog2(NREQ);
  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CYCLE - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_FRAMES);

  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_idx;
  logic            r_state;
  logic [PW-1:0]   r_owner;
  logic [PW-1:0]   r_rr_ptr;
  logic [HW-1:0]   r_hold;
  logic [15:0]     r_shadow;
  logic [NREQ-1:0] r_gnt;
  logic [7:0]      r_seg7;
  logic [3:0]      r_sel;
  logic            r_frame_done;

  logic            w_tick;
  logic            w_boundary;
  logic [15:0]     w_live;
  logic [3:0]      w_code;
  logic [7:0]      w_seg;
  logic [NREQ-1:0] w_mask;
  logic            w_found;
  logic [PW-1:0]   w_win;
  logic [PW-1:0]   w_cand;
  logic [HW-1:0]   w_hold_inc;
  logic            w_owner_req;

  assign w_tick      = (r_cnt == CNT_LAST);
  assign w_boundary  = w_tick && (r_idx == 2'd3);
  assign w_live      = data[{r_owner, 4'b0000} +: 16];
  // Digit 0 comes straight from the owner and seeds the shadow, so a frame never tears.
  assign w_code      = (r_idx == 2'd0) ? w_live[3:0] : r_shadow[{r_idx, 2'b00} +: 4];
  assign w_owner_req = req[r_owner];
  assign w_hold_inc  = (r_hold == HOLD_MAX) ? r_hold : r_hold + 1'b1;

  seg7_decoder u_decoder (
    .i_code (w_code),
    .o_seg  (w_seg)
  );

  // The current owner is masked out so it can never be re-granted to itself.
  always_comb begin
    w_mask  = req;
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    if (r_state == ST_OWN) w_mask[r_owner] = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = PW'((int'(r_rr_ptr) + k) % NREQ);
      if (!w_found && w_mask[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_idx        <= 2'd0;
      r_state      <= ST_IDLE;
      r_owner      <= '0;
      r_rr_ptr     <= PW'(NREQ - 1);
      r_hold       <= '0;
      r_shadow     <= 16'h0000;
      r_gnt        <= '0;
      r_seg7       <= 8'h00;
      r_sel        <= 4'b0000;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_boundary;
      r_cnt        <= w_tick ? '0 : r_cnt + 1'b1;

      if (w_tick) begin
        r_idx <= r_idx + 2'd1;
        if (r_idx == 2'd0) r_shadow <= w_live;
        if (r_state == ST_OWN) begin
          r_sel  <= digit_onehot(r_idx);
          r_seg7 <= w_seg;
        end else begin
          r_sel  <= 4'b0000;
          r_seg7 <= SEG_BLANK;
        end
      end

      if (w_boundary) begin
        if (r_state == ST_IDLE) begin
          if (w_found) begin
            r_state  <= ST_OWN;
            r_owner  <= w_win;
            r_rr_ptr <= w_win;
            r_gnt    <= {{(NREQ-1){1'b0}}, 1'b1} << w_win;
            r_hold   <= '0;
          end
        end else if (!w_owner_req && !w_found) begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
          r_hold  <= '0;
        end else if (w_found && (!w_owner_req || (w_hold_inc >= HOLD_MAX))) begin
          r_owner  <= w_win;
          r_rr_ptr <= w_win;
          r_gnt    <= {{(NREQ-1){1'b0}}, 1'b1} << w_win;
          r_hold   <= '0;
        end else begin
          r_hold <= w_hold_inc;
        end
      end
    end
  end

  assign gnt        = r_gnt;
  assign seg7       = r_seg7;
  assign seg7_sel   = r_sel;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Directed and randomized bench for seg7_display_arbiter against a cycle-counting
// behavioural model of the arbitration and scan rules.
module tb_seg7_display_arbiter;

  localparam int NREQ  = 4;
  localparam int CYCLE = 4;
  localparam int HOLD  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [63:0] data = 64'h0;
  logic [3:0]  gnt;
  logic [7:0]  seg7;
  logic [3:0]  seg7_sel;
  logic        frame_done;

  int n_checks = 0;
  int n_err    = 0;

  seg7_display_arbiter #(
    .NREQ        (NREQ),
    .CYCLE       (CYCLE),
    .HOLD_FRAMES (HOLD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .data       (data),
    .gnt        (gnt),
    .seg7       (seg7),
    .seg7_sel   (seg7_sel),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  logic [7:0] seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] t2_exp [4] = '{8'h06, 8'h5B, 8'h4F, 8'h66};
  logic [3:0] t3_exp [9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100,
                             4'b1000, 4'b1000, 4'b0001};

  // Model: edges counted since reset release; owner -1 means nobody holds the display.
  int          m_n;
  int          m_owner;
  int          m_rr;
  int          m_frames;
  logic [15:0] m_shadow;
  logic [3:0]  m_sel;
  logic [7:0]  m_seg;
  logic        m_fd;
  logic        m_bnd;

  function automatic int next_req(int start, int excl, logic [3:0] r);
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = (start + k) % NREQ;
      if (c != excl && r[c]) return c;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    int slot, c;
    logic tick;
    if (rst) begin
      m_n = 0; m_owner = -1; m_rr = NREQ - 1; m_frames = 0;
      m_shadow = 16'h0; m_sel = 4'b0; m_seg = 8'h0; m_fd = 1'b0; m_bnd = 1'b0;
      return;
    end
    tick  = (m_n % CYCLE) == CYCLE - 1;
    slot  = (m_n / CYCLE) % 4;
    m_bnd = tick && slot == 3;
    m_fd  = m_bnd;
    if (tick) begin
      if (m_owner < 0) begin
        m_sel = 4'b0; m_seg = 8'h0;
      end else begin
        if (slot == 0) m_shadow = data[m_owner*16 +: 16];
        m_sel = 4'(1 << slot);
        m_seg = seg_tab[m_shadow[slot*4 +: 4]];
      end
    end
    if (m_bnd) begin
      if (m_owner < 0) begin
        c = next_req(m_rr, -1, req);
        if (c >= 0) begin m_owner = c; m_rr = c; m_frames = 0; end
      end else begin
        m_frames = (m_frames + 1 > HOLD) ? HOLD : m_frames + 1;
        c = next_req(m_owner, m_owner, req);
        if (!req[m_owner] && c < 0) m_owner = -1;
        else if (c >= 0 && (!req[m_owner] || m_frames >= HOLD)) begin
          m_owner = c; m_rr = c; m_frames = 0;
        end
      end
    end
    m_n++;
  endtask

  task automatic step();
    logic [3:0] eg;
    @(posedge clk);
    model_edge();
    #1;
    eg = (m_owner < 0) ? 4'b0 : 4'(1 << m_owner);
    chk("gnt", {4'b0, gnt}, {4'b0, eg});
    chk("sel", {4'b0, seg7_sel}, {4'b0, m_sel});
    chk("seg", seg7, m_seg);
    chk("frame_done", {7'b0, frame_done}, {7'b0, m_fd});
  endtask

  task automatic run_to_boundary();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      step();
      found = m_bnd;
    end
    n_checks++;
    assert (found) else begin
      n_err++;
      $error("FAIL boundary_wait got=none exp=boundary_within_64_clk");
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_gnt", {4'b0, gnt}, 8'h00);
    chk("rst_sel", {4'b0, seg7_sel}, 8'h00);
    chk("rst_seg", seg7, 8'h00);
    chk("rst_fd", {7'b0, frame_done}, 8'h00);
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int pulses;
    #2;
    do_reset();

    // Idle: three frames, blank display, frame pulses every 16 clk
    pulses = 0;
    for (int i = 0; i < 48; i++) begin
      step();
      if (frame_done) pulses++;
    end
    chk("t1_pulses", 8'(pulses), 8'd3);
    chk("t1_gnt", {4'b0, gnt}, 8'h00);

    // Single owner, digit order and decode
    req = 4'b0001;
    data[15:0] = 16'h4321;
    run_to_boundary();
    chk("t2_gnt", {4'b0, gnt}, 8'h01);
    for (int d = 0; d < 4; d++) begin
      repeat (CYCLE) step();
      chk("t2_sel", {4'b0, seg7_sel}, 8'(1 << d));
      chk("t2_seg", seg7, t2_exp[d]);
    end

    // All requesting: rotation with two-frame hold
    do_reset();
    req = 4'hF;
    for (int b = 0; b < 9; b++) begin
      run_to_boundary();
      chk("t3_gnt", {4'b0, gnt}, {4'b0, t3_exp[b]});
    end

    // Release ignores hold; release with no others goes idle
    do_reset();
    req = 4'b0001;
    run_to_boundary();
    chk("t4_gnt0", {4'b0, gnt}, 8'h01);
    req = 4'b0100;
    run_to_boundary();
    chk("t4_gnt2", {4'b0, gnt}, 8'h04);
    req = 4'b0000;
    run_to_boundary();
    chk("t4_idle", {4'b0, gnt}, 8'h00);
    repeat (CYCLE) step();
    chk("t4_sel", {4'b0, seg7_sel}, 8'h00);
    chk("t4_seg", seg7, 8'h00);

    // Mid-frame data change is deferred to the next frame
    do_reset();
    data = 64'h0;
    req = 4'b0001;
    run_to_boundary();
    repeat (2 * CYCLE) step();
    data[15:0] = 16'hAAAA;
    repeat (CYCLE) step();
    chk("t5_sel2", {4'b0, seg7_sel}, 8'h04);
    chk("t5_seg2", seg7, 8'h3F);
    repeat (CYCLE) step();
    chk("t5_sel3", {4'b0, seg7_sel}, 8'h08);
    chk("t5_seg3", seg7, 8'h3F);
    for (int d = 0; d < 4; d++) begin
      repeat (CYCLE) step();
      chk("t5_dash_sel", {4'b0, seg7_sel}, 8'(1 << d));
      chk("t5_dash_seg", seg7, 8'h40);
    end
    data[15:0] = 16'hFFFF;
    for (int d = 0; d < 4; d++) begin
      repeat (CYCLE) step();
      chk("t5_blank_sel", {4'b0, seg7_sel}, 8'(1 << d));
      chk("t5_blank_seg", seg7, 8'h00);
    end

    // Reset mid-frame while owning; round-robin pointer restarts
    repeat (6) step();
    chk("t6_pre_gnt", {4'b0, gnt}, 8'h01);
    req = 4'b0010;
    do_reset();
    run_to_boundary();
    chk("t6_gnt1", {4'b0, gnt}, 8'h02);

    // Randomized requests and data against the model
    do_reset();
    for (int it = 0; it < 80; it++) begin
      req  = 4'($urandom_range(0, 15));
      data = {$urandom(), $urandom()};
      repeat ($urandom_range(1, 24)) step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
